// File: rtl/jt900h_mul_if.sv
// jt900h_mul_if: operand/control bundle between the ALU sequencer
// and the shift-and-add multiplier.
interface jt900h_mul_if;
    logic        cen;
    logic [15:0] op0;
    logic [15:0] op1;
    logic        len;
    logic        sgn;
    logic        start;
    logic [31:0] prod;
    logic        busy;

    modport master (
        output cen, op0, op1, len, sgn, start,
        input  prod, busy
    );

    modport slave (
        input  cen, op0, op1, len, sgn, start,
        output prod, busy
    );
endinterface

// File: rtl/jt900h_mul.sv
// jt900h_mul: iterative 8x8/16x16 signed/unsigned multiplier,
// one product bit per enabled clock.
module jt900h_mul (
    input  logic           rst,
    input  logic           clk,
    jt900h_mul_if.slave    bus
);
    logic [31:0] acc;
    logic [31:0] mcand;
    logic [15:0] mult;
    logic [3:0]  st;
    logic        neg;
    logic        len_r;
    logic        sgn_r;

    logic [15:0] ext_a, ext_b;
    logic [15:0] mag_a, mag_b;
    logic        msb_a, msb_b;
    logic [31:0] fin, res;

    // Operands sign-extended first so byte magnitudes come out right
    always_comb begin
        ext_a = bus.len ? bus.op0 : {{8{bus.op0[7]}}, bus.op0[7:0]};
        ext_b = bus.len ? bus.op1 : {{8{bus.op1[7]}}, bus.op1[7:0]};
        msb_a = bus.len ? bus.op0[15] : bus.op0[7];
        msb_b = bus.len ? bus.op1[15] : bus.op1[7];
        mag_a = bus.len ? bus.op0 : {8'h00, bus.op0[7:0]};
        mag_b = bus.len ? bus.op1 : {8'h00, bus.op1[7:0]};
        if (bus.sgn && msb_a) mag_a = -ext_a;
        if (bus.sgn && msb_b) mag_b = -ext_b;
    end

    always_comb begin
        fin = acc + (mult[0] ? mcand : 32'd0);
        res = neg ? -fin : fin;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc      <= 32'd0;
            mcand    <= 32'd0;
            mult     <= 16'd0;
            st       <= 4'd0;
            neg      <= 1'b0;
            len_r    <= 1'b0;
            sgn_r    <= 1'b0;
            bus.busy <= 1'b0;
            bus.prod <= 32'd0;
        end else if (bus.cen) begin
            if (bus.start) begin
                bus.busy <= 1'b1;
                bus.prod <= 32'd0;
                acc      <= 32'd0;
                mcand    <= {16'h0000, mag_a};
                mult     <= mag_b;
                neg      <= bus.sgn & (msb_a ^ msb_b);
                st       <= bus.len ? 4'd0 : 4'd8;
                len_r    <= bus.len;
                sgn_r    <= bus.sgn;
            end else if (bus.busy) begin
                acc   <= fin;
                mcand <= mcand << 1;
                mult  <= mult >> 1;
                st    <= st + 4'd1;
                if (st == 4'd15) begin
                    bus.busy <= 1'b0;
                    if (len_r)
                        bus.prod <= res;
                    else
                        bus.prod <= {sgn_r ? {16{res[15]}} : 16'h0000,
                                     res[15:0]};
                end
            end
        end
    end
endmodule
